// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex driver for NUM_DIGITS common-anode 7-segment digits with
// double-buffered loading, blanking, leading-zero suppression and dead time; HEXSCAN_BLINK_EN adds digit blinking.
module hex_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 64,
`ifdef HEXSCAN_BLINK_EN
  parameter int BLINK_FRAMES = 256,
`endif
  localparam int CNT_W = $clog2(CLK_DIV)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
`ifdef HEXSCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [4*NUM_DIGITS-1:0] pending_r;
  logic [4*NUM_DIGITS-1:0] active_r;
  logic                    pend_valid_r;
  logic [NUM_DIGITS-1:0]   supp_s;
  logic                    nz_s;
  logic [3:0]              nib_s;
  logic                    blank_s;
  logic                    lit_s;
  logic [6:0]              seg_s;
  logic [NUM_DIGITS-1:0]   an_s;
  logic                    slot_end_s;
  logic                    frame_wrap_s;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'h3F;
      4'h1:    code = 7'h06;
      4'h2:    code = 7'h5B;
      4'h3:    code = 7'h4F;
      4'h4:    code = 7'h66;
      4'h5:    code = 7'h6D;
      4'h6:    code = 7'h7D;
      4'h7:    code = 7'h07;
      4'h8:    code = 7'h7F;
      4'h9:    code = 7'h6F;
      4'hA:    code = 7'h77;
      4'hB:    code = 7'h7C;
      4'hC:    code = 7'h39;
      4'hD:    code = 7'h5E;
      4'hE:    code = 7'h79;
      4'hF:    code = 7'h71;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

  assign slot_end_s   = (cnt_r == CNT_LAST);
  assign frame_wrap_s = slot_end_s && (idx_r == IDX_LAST);

`ifdef HEXSCAN_BLINK_EN
  localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);
  logic [FCNT_W-1:0] fcnt_r;
  logic              blink_phase_r;

  // Blink phase flips after every BLINK_FRAMES frame wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_r        <= {FCNT_W{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (frame_wrap_s) begin
      if (fcnt_r == FCNT_LAST) begin
        fcnt_r        <= {FCNT_W{1'b0}};
        blink_phase_r <= ~blink_phase_r;
      end else begin
        fcnt_r <= fcnt_r + FCNT_W'(1);
      end
    end
  end
`endif

  // Leading-zero mask: a digit is suppressible while every nibble from it upward is zero
  always_comb begin
    supp_s = {NUM_DIGITS{1'b0}};
    nz_s   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      nz_s      = nz_s | (active_r[4*i +: 4] != 4'h0);
      supp_s[i] = ~nz_s;
    end
  end

  // Next segment/anode pattern for the digit currently being scanned
  always_comb begin
    nib_s   = active_r[{idx_r, 2'b00} +: 4];
    blank_s = ~digit_en[idx_r] | (lz_suppress & supp_s[idx_r]);
`ifdef HEXSCAN_BLINK_EN
    blank_s = blank_s | (blink_phase_r & blink_mask[idx_r]);
`endif
    lit_s = ~blank_s && (cnt_r >= CNT_BLANK);
    if (lit_s) begin
      seg_s = ~hex_to_seg(nib_s);
      an_s  = ~(NUM_DIGITS'(1) << idx_r);
    end else begin
      seg_s = 7'h7F;
      an_s  = {NUM_DIGITS{1'b1}};
    end
  end

  // Scan counters, double buffer and registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r        <= {CNT_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      pending_r    <= {(4*NUM_DIGITS){1'b0}};
      active_r     <= {(4*NUM_DIGITS){1'b0}};
      pend_valid_r <= 1'b0;
      seg          <= 7'h7F;
      an           <= {NUM_DIGITS{1'b1}};
      frame_done   <= 1'b0;
    end else begin
      cnt_r <= slot_end_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      if (slot_end_s) begin
        idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
      end
      frame_done <= frame_wrap_s;
      seg        <= seg_s;
      an         <= an_s;
      // A load landing on the wrap itself bypasses pending so it is shown next frame
      if (frame_wrap_s) begin
        pend_valid_r <= 1'b0;
        if (load) begin
          active_r <= value;
        end else if (pend_valid_r) begin
          active_r <= pending_r;
        end
      end else if (load) begin
        pending_r    <= value;
        pend_valid_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner (NUM_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=1).
module tb_hex_display_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_suppress = 1'b0;
  logic [3:0]  blink_mask = 4'h0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      en;
    logic            lz;
    logic [3:0][6:0] es;
  } vec_t;
  vec_t vecs[8];

  hex_display_scanner #(
    .NUM_DIGITS(4),
    .CLK_DIV(4),
    .BLANK_CYCLES(1)
`ifdef HEXSCAN_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .load(load),
    .digit_en(digit_en),
    .lz_suppress(lz_suppress),
`ifdef HEXSCAN_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg(seg),
    .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // At most one anode may be low at any time
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL an_onehot: an=%b, required at most one zero bit", an);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic wait_fd();
    int n = 0;
    while (!frame_done && n < 40) begin
      step();
      n++;
    end
    chk("frame_done_timeout", {31'd0, frame_done}, 32'd1);
  endtask

  // Called at a frame_done sample; checks all 16 output cycles of the next frame
  task automatic check_frame(input logic [3:0][6:0] es, input string name);
    exp_t e;
    exp_t g;
    int d;
    int ph;
    for (int k = 1; k <= 16; k++) begin
      d  = (k - 1) / 4;
      ph = (k - 1) % 4;
      e.seg = (ph >= 1) ? es[d] : 7'h7F;
      e.an  = (ph >= 1 && es[d] != 7'h7F) ? ~(4'b0001 << d) : 4'hF;
      e.fd  = (k == 16);
      sb_q.push_back(e);
      step();
      g = sb_q.pop_front();
      checks++;
      if (seg !== g.seg || an !== g.an || frame_done !== g.fd) begin
        errors++;
        $display("FAIL %s k=%0d: seg=%h an=%h fd=%b, expected seg=%h an=%h fd=%b",
                 name, k, seg, an, frame_done, g.seg, g.an, g.fd);
      end
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{16'h12AF, 4'hF,    1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}};
    vecs[1] = '{16'h0030, 4'hF,    1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}};
    vecs[2] = '{16'h0000, 4'hF,    1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{16'h0000, 4'hF,    1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[4] = '{16'h89CD, 4'b1010, 1'b0, {7'h00, 7'h7F, 7'h46, 7'h7F}};
    vecs[5] = '{16'h0B07, 4'hF,    1'b1, {7'h7F, 7'h03, 7'h40, 7'h78}};
    vecs[6] = '{16'h3456, 4'hF,    1'b0, {7'h30, 7'h19, 7'h12, 7'h02}};
    vecs[7] = '{16'h00E0, 4'b1101, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};

    // Reset values and first lit cycle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_c1_an", {28'd0, an}, 32'hF);
    chk("post_rst_c1_seg", {25'd0, seg}, 32'h7F);
    step();
    chk("post_rst_c2_an", {28'd0, an}, 32'hE);
    chk("post_rst_c2_seg", {25'd0, seg}, 32'h40);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      digit_en    = vecs[i].en;
      lz_suppress = vecs[i].lz;
      do_load(vecs[i].value);
      wait_fd();
      check_frame(vecs[i].es, $sformatf("vec%0d", i));
    end

    // Two loads mid-frame: current frame keeps old value, next frame shows the last load
    digit_en    = 4'hF;
    lz_suppress = 1'b0;
    do_load(16'h7777);
    wait_fd();
    repeat (4) step();
    do_load(16'h1111);
    do_load(16'h2222);
    n = 0;
    while (!frame_done && n < 40) begin
      step();
      n++;
      if (an != 4'hF) chk("no_tear_seg", {25'd0, seg}, 32'h78);
    end
    chk("frame_done_timeout", {31'd0, frame_done}, 32'd1);
    check_frame({7'h24, 7'h24, 7'h24, 7'h24}, "last_load_wins");

    // Load on the wrap cycle reaches active directly and leaves no stale pending
    repeat (15) step();
    value = 16'h5555;
    load  = 1'b1;
    step();
    load  = 1'b0;
    chk("wrap_fd", {31'd0, frame_done}, 32'd1);
    check_frame({7'h12, 7'h12, 7'h12, 7'h12}, "wrap_load");
    check_frame({7'h12, 7'h12, 7'h12, 7'h12}, "no_stale_pending");

    // Asynchronous reset mid-frame
    blink_mask = 4'b0001;
    repeat (6) step();
    rst = 1'b1;
    #1;
    chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
    chk("mid_rst_an", {28'd0, an}, 32'hF);
    chk("mid_rst_fd", {31'd0, frame_done}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("restart_c1_an", {28'd0, an}, 32'hF);
    step();
    chk("restart_c2_an", {28'd0, an}, 32'hE);
    chk("restart_c2_seg", {25'd0, seg}, 32'h40);

    do_load(16'h7777);
    wait_fd();
`ifdef HEXSCAN_BLINK_EN
    check_frame({7'h78, 7'h78, 7'h78, 7'h78}, "blink_f1");
    check_frame({7'h78, 7'h78, 7'h78, 7'h7F}, "blink_f2");
    check_frame({7'h78, 7'h78, 7'h78, 7'h7F}, "blink_f3");
    check_frame({7'h78, 7'h78, 7'h78, 7'h78}, "blink_f4");
`else
    check_frame({7'h78, 7'h78, 7'h78, 7'h78}, "after_restart");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion before 200000");
    $fatal(1);
  end
endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Time-multiplexed driver for a bank of NUM_DIGITS common-anode 7-segment displays.
- Takes a packed hex word and scans one digit per slot, driving the shared active-low segment bus and the active-low anode selects.
- Adds double-buffered loading, per-digit blanking, leading-zero suppression and anti-ghosting dead time.
- Sits between the datapath result registers and the board display pins; replaces per-digit combinational hex decoders.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- CLK_DIV, 50000, clk cycles per digit slot (>= BLANK_CYCLES+1).
- BLANK_CYCLES, 64, cycles at the start of each slot with all anodes off (0 = no dead time).
- CNT_W, $clog2(CLK_DIV), prescaler width; derived, never overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- value  in  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 rightmost.
- load  in  1  capture value into the pending buffer this cycle.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit.
- lz_suppress  in  1  1 = blank leading zero digits.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  NUM_DIGITS  anode selects, active-low, one-hot-low when lit.
- frame_done  out  1  one-cycle pulse when the last digit slot ends.

Behaviour:
- Reset (asynchronous, immediate):
  - prescaler cnt=0, digit index idx=0, pending=0, active=0, pend_valid=0.
  - seg=7'b1111111, an=all ones, frame_done=0.
- Prescaler: cnt counts 0..CLK_DIV-1 and wraps to 0.
  - At cnt==CLK_DIV-1, idx advances; NUM_DIGITS-1 wraps to 0 (frame wrap).
- frame_done: registered; high for exactly the cycle after the frame-wrap cycle.
- Double buffer:
  - load=1 writes value to pending and sets pend_valid.
  - At frame wrap, if pend_valid, active<=pending and pend_valid<=0. The display never tears mid-frame.
  - load on the frame-wrap cycle itself: value goes straight to active and pend_valid stays 0.
  - Repeated loads within one frame: the last one wins.
- Segment encoding (before inversion), hex 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71. seg = ~code.
- Blank digit: seg=7'b1111111 and that digit's an stays 1.
  - A digit is blank if digit_en[idx]==0, or if it is suppressed as a leading zero.
- Leading-zero suppression (lz_suppress=1):
  - Digit i is suppressed if its nibble and all higher nibbles of active are 0.
  - Digit 0 is never suppressed: value 0 shows a single "0".
  - Evaluated combinationally from active each cycle.
- Anode timing:
  - an[i]=0 only when idx==i, cnt>=BLANK_CYCLES and the digit is not blank. Otherwise an[i]=1.
  - At most one an bit is low in any cycle.
- Latency: seg/an are registered from the previous cycle's idx/cnt/active, so one-cycle latency.
- digit_en and lz_suppress are not buffered; a change takes effect one cycle later.
- Reset mid-frame: outputs go to reset values at once. Scanning restarts at digit 0 with cnt=0 after rst deasserts.

Optional Feature:
- Macro HEXSCAN_BLINK_EN.
- When defined:
  - Adds input blink_mask [NUM_DIGITS-1:0] and parameter BLINK_FRAMES (default 256).
  - A frame counter toggles blink_phase every BLINK_FRAMES frame wraps; blink_phase resets to 0.
  - Digits with blink_mask[i]=1 are treated as blank while blink_phase==1.
- When undefined: no blink_mask port, no frame counter, and behaviour is exactly as above.

Test Plan:
- Reset with NUM_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=1 -> seg=7'h7F, an=4'hF, frame_done=0 during rst. After release, digit 0 is lit (an=4'hE) from the third cycle.
- load value=16'h12AF, all digit_en=1, lz_suppress=0 -> the following frame shows seg ~71,~77,~5B,~06 on an=E,D,B,7. frame_done pulses once every 16 cycles.
- lz_suppress=1, load 16'h0030 -> digits 3 and 2 keep an=1 and seg=7F; digit 1 shows ~4F and digit 0 shows ~3F. Then load 16'h0000 -> only digit 0 lit, showing ~3F.
- Load 16'h1111 mid-frame, then 16'h2222 in the same frame -> the current frame keeps the old value and the next frame shows all "2" (~5B). Load on the wrap cycle -> visible in the immediately following frame.
- Across all cycles -> an never has more than one 0 bit, and an=4'hF on every cycle with cnt<1.
- HEXSCAN_BLINK_EN with BLINK_FRAMES=2, blink_mask=4'b0001 -> digit 0 alternates lit/blank every 2 frames; other digits stay lit.
